led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
- REQ-001 Parameter WIDTH, default 16, LED vector width; legal range 2..64.
- REQ-002 Parameter DIV_W, default 32, prescaler divisor width.
- REQ-003 Parameter RST_DIV, default 5000000, informational default divisor for the package constant; not used internally.
- REQ-004 clk  in  1  single clock; all state on rising edge.
- REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- REQ-006 en  in  1  1 = prescaler runs and pattern advances; 0 = freeze all state.
- REQ-007 mode  in  2  pattern select: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary up-count.
- REQ-008 div  in  DIV_W  step period minus one, in clk cycles; 0 = step every cycle.
- REQ-009 load  in  1  one-cycle request to overwrite pattern.
- REQ-010 load_val  in  WIDTH  value written on load.
- REQ-011 led  out  WIDTH  registered pattern output.
- REQ-012 tick  out  1  registered one-cycle pulse, high in the cycle after each pattern step.

Function
- REQ-013 Prescaler cnt (DIV_W bits) SHALL increment each en=1 cycle; when cnt >= div it SHALL produce an internal step and wrap to 0.
- REQ-014 Step period SHALL be exactly div+1 en=1 cycles; en=0 cycles SHALL hold cnt, led, direction and mode_q.
- REQ-015 If div is lowered below current cnt, the next en=1 cycle SHALL step (>= compare, no 2^DIV_W wrap).
- REQ-016 mode SHALL be sampled into mode_q only on a step edge; the step taken on that edge SHALL already use the new mode.
- REQ-017 Rotate-left step: led <= {led[WIDTH-2:0], led[WIDTH-1]}; rotate-right: led <= {led[0], led[WIDTH-1:1]}.
- REQ-018 Bounce SHALL use a direction register dir (LEFT/RIGHT): LEFT and led[WIDTH-1]=1 -> dir<=RIGHT, led<=led>>1; LEFT otherwise -> led<=led<<1; RIGHT mirrored using led[0].
- REQ-019 Count mode: led <= led+1 modulo 2^WIDTH (all-ones wraps to 0).
- REQ-020 In rotate and bounce modes a step with led==0 SHALL set led to 1 and dir to LEFT (no dead pattern).
- REQ-021 load=1 SHALL write led<=load_val, cnt<=0, dir<=LEFT on that edge, regardless of en, and SHALL suppress any coincident step and tick.
- REQ-022 tick SHALL be 1 in the cycle following each step edge and 0 otherwise; never asserted for load.
- REQ-023 Output led latency: change visible on the clock edge that produces the step; no combinational path from inputs to led or tick.

Reset
- REQ-024 rst=0 SHALL asynchronously force led=1 (LSB only), cnt=0, dir=LEFT, mode_q=00, tick=0.
- REQ-025 Release SHALL be clean mid-period: first step occurs div+1 en=1 cycles after the first rising edge with rst=1.
- REQ-026 Reset asserted mid-bounce or mid-count SHALL discard all state; no step or tick in the deassertion cycle.

Structure
- REQ-027 Package led_pkg SHALL hold the mode enum (ROT_L, ROT_R, BOUNCE, COUNT), the dir enum and DEFAULT_DIV = 5000000.
- REQ-028 Prescaler SHALL be a sub-module led_prescaler (inputs clk, rst, en, clr, div; output step); pattern logic lives in the top.
- REQ-029 No simulation-only constructs (display, finish, dump) in synthesisable RTL.

Verification (WIDTH=8 unless stated)
- REQ-030 Reset, div=2, en=1, mode=00 -> led 01,02,04,...,80,01 with steps every 3 cycles; tick one cycle after each.
- REQ-031 mode=10, div=0 from led=01 -> 01,02,...,80,40,20,...,01,02; dir flips exactly at 80 and 01.
- REQ-032 mode=11, load_val=FE, load -> steps FF, 00, 01; tick pulses three times, none on load cycle.
- REQ-033 div=9, cnt reaches 6, div changed to 3 -> step on next en cycle, then period 4.
- REQ-034 en=0 for 20 cycles mid-period -> led, tick, cnt frozen; resumes remaining count on en=1; mode change while en=0 takes effect only at next step.
- REQ-035 rst pulsed low asynchronously between edges during bounce at led=20 -> led=01 immediately, tick=0, dir=LEFT after release.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'b00,
    ROT_R  = 2'b01,
    BOUNCE = 2'b10,
    COUNT  = 2'b11
  } mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam int unsigned DEFAULT_DIV = 5000000;

endpackage

// File: rtl/led_prescaler.sv
// Free-running step prescaler: one step every div+1 enabled cycles, clearable.
module led_prescaler #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             reached;

  // >= rather than == so lowering div below cnt steps at once instead of wrapping.
  assign reached = (cnt_q >= div);
  assign step    = en && !clr && reached;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = reached ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate, bounce or count, advanced by a prescaled step.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned RST_DIV = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick
);

  // RST_DIV only documents the intended board divisor; nothing depends on it.
  if (RST_DIV == 0) begin : g_no_default_div
  end

  logic [WIDTH-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  mode_e            mode_q, mode_d;
  mode_e            cur_mode;
  logic             tick_q, tick_d;
  logic             step;

  // A load clears the prescaler, which also masks any step on that edge.
  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .div  (div),
    .step (step)
  );

  always_comb begin
    led_d    = led_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    cur_mode = mode_q;
    if (load) begin
      led_d = load_val;
      dir_d = LEFT;
    end else if (step) begin
      // Mode is latched on the step edge and that same step already obeys it.
      cur_mode = mode_e'(mode);
      mode_d   = cur_mode;
      tick_d   = 1'b1;
      unique case (cur_mode)
        ROT_L: begin
          if (led_q == '0) begin
            led_d = WIDTH'(1);
            dir_d = LEFT;
          end else begin
            led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          end
        end
        ROT_R: begin
          if (led_q == '0) begin
            led_d = WIDTH'(1);
            dir_d = LEFT;
          end else begin
            led_d = {led_q[0], led_q[WIDTH-1:1]};
          end
        end
        BOUNCE: begin
          if (led_q == '0) begin
            led_d = WIDTH'(1);
            dir_d = LEFT;
          end else if (dir_q == LEFT) begin
            if (led_q[WIDTH-1]) begin
              dir_d = RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        COUNT: begin
          led_d = led_q + WIDTH'(1);
        end
        default: begin
          led_d = led_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q  <= WIDTH'(1);
      dir_q  <= LEFT;
      mode_q <= ROT_L;
      tick_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen at WIDTH=8.
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [31:0] div;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  led;
  logic        tick;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(
    .WIDTH (8),
    .DIV_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .div      (div),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst = 1'b0; en = 1'b0; load = 1'b0; mode = 2'b00; div = 32'd2; load_val = 8'h00;
    repeat (3) edge1();
    checks++;
    if (led !== 8'h01 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: led=%h tick=%b, expected led=01 tick=0", led, tick);
    end
    rst = 1'b1; en = 1'b1;
    exp = 8'h01;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 3; c++) begin
        edge1();
        checks++;
        if (c < 2) begin
          if (led !== exp || tick !== 1'b0) begin
            errors++;
            $display("FAIL rotl_hold s%0d c%0d: led=%h tick=%b, expected led=%h tick=0",
                     s, c, led, tick, exp);
          end
        end else begin
          exp = {exp[6:0], exp[7]};
          if (led !== exp || tick !== 1'b1) begin
            errors++;
            $display("FAIL rotl_step s%0d: led=%h tick=%b, expected led=%h tick=1",
                     s, led, tick, exp);
          end
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] seq [15];
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    en = 1'b1; mode = 2'b10; div = 32'd0; load_val = 8'h01; load = 1'b1;
    edge1();
    load = 1'b0;
    checks++;
    if (led !== 8'h01 || tick !== 1'b0) begin
      errors++;
      $display("FAIL bounce_load: led=%h tick=%b, expected led=01 tick=0", led, tick);
    end
    for (int i = 0; i < 15; i++) begin
      edge1();
      checks++;
      if (led !== seq[i] || tick !== 1'b1) begin
        errors++;
        $display("FAIL bounce_step %0d: led=%h tick=%b, expected led=%h tick=1",
                 i, led, tick, seq[i]);
      end
    end
  endtask

  task automatic test_count();
    logic [7:0] seq [3];
    seq = '{8'hFF, 8'h00, 8'h01};
    en = 1'b1; mode = 2'b11; div = 32'd0; load_val = 8'hFE; load = 1'b1;
    edge1();
    load = 1'b0;
    checks++;
    if (led !== 8'hFE || tick !== 1'b0) begin
      errors++;
      $display("FAIL count_load: led=%h tick=%b, expected led=fe tick=0", led, tick);
    end
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (led !== seq[i] || tick !== 1'b1) begin
        errors++;
        $display("FAIL count_step %0d: led=%h tick=%b, expected led=%h tick=1",
                 i, led, tick, seq[i]);
      end
    end
    en = 1'b0;
    edge1();
    checks++;
    if (led !== 8'h01 || tick !== 1'b0) begin
      errors++;
      $display("FAIL count_stop: led=%h tick=%b, expected led=01 tick=0", led, tick);
    end
  endtask

  task automatic test_div_change();
    en = 1'b1; mode = 2'b00; div = 32'd9; load_val = 8'h01; load = 1'b1;
    edge1();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      edge1();
      checks++;
      if (led !== 8'h01 || tick !== 1'b0) begin
        errors++;
        $display("FAIL div9_hold %0d: led=%h tick=%b, expected led=01 tick=0", i, led, tick);
      end
    end
    div = 32'd3;
    edge1();
    checks++;
    if (led !== 8'h02 || tick !== 1'b1) begin
      errors++;
      $display("FAIL div_lowered: led=%h tick=%b, expected led=02 tick=1", led, tick);
    end
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (led !== 8'h02 || tick !== 1'b0) begin
        errors++;
        $display("FAIL div3_hold %0d: led=%h tick=%b, expected led=02 tick=0", i, led, tick);
      end
    end
    edge1();
    checks++;
    if (led !== 8'h04 || tick !== 1'b1) begin
      errors++;
      $display("FAIL div3_step: led=%h tick=%b, expected led=04 tick=1", led, tick);
    end
  endtask

  task automatic test_freeze();
    en = 1'b1; mode = 2'b00; div = 32'd3; load_val = 8'h01; load = 1'b1;
    edge1();
    load = 1'b0;
    repeat (2) edge1();
    en = 1'b0; mode = 2'b01;
    for (int i = 0; i < 20; i++) begin
      edge1();
      checks++;
      if (led !== 8'h01 || tick !== 1'b0) begin
        errors++;
        $display("FAIL freeze %0d: led=%h tick=%b, expected led=01 tick=0", i, led, tick);
      end
    end
    en = 1'b1;
    edge1();
    checks++;
    if (led !== 8'h01 || tick !== 1'b0) begin
      errors++;
      $display("FAIL resume_hold: led=%h tick=%b, expected led=01 tick=0", led, tick);
    end
    edge1();
    checks++;
    if (led !== 8'h80 || tick !== 1'b1) begin
      errors++;
      $display("FAIL resume_step: led=%h tick=%b, expected led=80 tick=1", led, tick);
    end
    repeat (3) edge1();
    checks++;
    if (led !== 8'h80 || tick !== 1'b0) begin
      errors++;
      $display("FAIL resume_period: led=%h tick=%b, expected led=80 tick=0", led, tick);
    end
    edge1();
    checks++;
    if (led !== 8'h40 || tick !== 1'b1) begin
      errors++;
      $display("FAIL resume_step2: led=%h tick=%b, expected led=40 tick=1", led, tick);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    en = 1'b1; mode = 2'b10; div = 32'd0; load_val = 8'h01; load = 1'b1;
    edge1();
    load = 1'b0;
    repeat (9) edge1();
    checks++;
    if (led !== 8'h20 || tick !== 1'b1) begin
      errors++;
      $display("FAIL bounce_pre_rst: led=%h tick=%b, expected led=20 tick=1", led, tick);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (led !== 8'h01 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: led=%h tick=%b, expected led=01 tick=0", led, tick);
    end
    #2 rst = 1'b1;
    exp = 8'h01;
    for (int i = 0; i < 7; i++) begin
      edge1();
      exp = exp << 1;
      checks++;
      if (led !== exp || tick !== 1'b1) begin
        errors++;
        $display("FAIL post_rst_step %0d: led=%h tick=%b, expected led=%h tick=1",
                 i, led, tick, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_count();
    test_div_change();
    test_freeze();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
